aclk_fsm: RTL and testbench

//  Control FSM for alarm-clock keypad entry. It sequences key shifting into the new-time shift register.
//  It issues the one-cycle load strobes to the alarm register (load_new_a) and the current-time counter (load_new_c).
//  It selects what the display shows. It sits between the keypad/buttons and the alarm register, time counter and display mux.

---
 rtl/aclk_pkg.sv | 16 +
 rtl/aclk_if.sv | 20 ++
 rtl/aclk_timeout_cnt.sv | 21 ++
 rtl/aclk_fsm.sv | 57 +++++
 tb/tb_aclk_fsm.sv | 139 +++++++++++++
 5 files changed

// File: rtl/aclk_pkg.sv
// aclk_pkg: shared state encoding, key codes and key decode for the alarm-clock entry FSM.
package aclk_pkg;
    typedef enum logic [6:0] {
        IDLE             = 7'b0000001,
        KEY_STORED       = 7'b0000010,
        KEY_WAITED       = 7'b0000100,
        KEY_ENTRY        = 7'b0001000,
        SHOW_ALARM       = 7'b0010000,
        SET_ALARM_TIME   = 7'b0100000,
        SET_CURRENT_TIME = 7'b1000000
    } state_t;
    localparam logic [3:0] NOKEY = 4'hA;
    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction
endpackage

// File: rtl/aclk_if.sv
// aclk_if: keypad/button inputs and load/display controls of the alarm-clock entry FSM.
interface aclk_if;
    logic       one_second;
    logic [3:0] key;
    logic       alarm_button;
    logic       time_button;
    logic       load_new_a;
    logic       load_new_c;
    logic       show_a;
    logic       show_new_time;
    logic       shift;
    modport master (
        output one_second, key, alarm_button, time_button,
        input  load_new_a, load_new_c, show_a, show_new_time, shift
    );
    modport slave (
        input  one_second, key, alarm_button, time_button,
        output load_new_a, load_new_c, show_a, show_new_time, shift
    );
endinterface

// File: rtl/aclk_timeout_cnt.sv
// aclk_timeout_cnt: counts one_second ticks during key entry and flags the tick that abandons it.
module aclk_timeout_cnt #(
    parameter int KEY_TIMEOUT_S = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic tick,
    output logic expired
);
    localparam int W = $clog2(KEY_TIMEOUT_S + 1);
    localparam logic [W-1:0] LAST = W'(KEY_TIMEOUT_S - 1);
    localparam logic [W-1:0] FULL = W'(KEY_TIMEOUT_S);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk or negedge reset)
        if (!reset) r_cnt <= '0;
        else if (clr) r_cnt <= '0;
        else if (en && tick && r_cnt != FULL) r_cnt <= r_cnt + W'(1);
    assign expired = en && tick && r_cnt == LAST;
endmodule

// File: rtl/aclk_fsm.sv
// aclk_fsm: Moore control FSM for alarm-clock keypad entry, load strobes and display select.
// Optional ACLK_DIGIT_CHECK_EN: refuse loads until four digits have been keyed.
import aclk_pkg::*;
module aclk_fsm #(
    parameter int KEY_TIMEOUT_S = 10
) (
    input logic   clk,
    input logic   reset,
    aclk_if.slave bus
);
    state_t r_state, w_next;
    logic   w_digit, w_timeout, w_enough, w_clr, w_key_state;
    assign w_digit     = is_digit(bus.key);
    assign w_key_state = r_state inside {KEY_WAITED, KEY_ENTRY};
    assign w_clr       = w_next == KEY_STORED;
    aclk_timeout_cnt #(.KEY_TIMEOUT_S(KEY_TIMEOUT_S)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (w_clr),
        .en      (w_key_state),
        .tick    (bus.one_second),
        .expired (w_timeout)
    );
`ifdef ACLK_DIGIT_CHECK_EN
    logic [2:0] r_digits;
    always_ff @(posedge clk or negedge reset)
        if (!reset) r_digits <= '0;
        else if (r_state == IDLE) r_digits <= '0;
        else if (r_state == KEY_STORED && r_digits != 3'd4) r_digits <= r_digits + 3'd1;
    assign w_enough = r_digits == 3'd4;
`else
    assign w_enough = 1'b1;
`endif
    always_ff @(posedge clk or negedge reset)
        if (!reset) r_state <= IDLE;
        else r_state <= w_next;
    // Buttons outrank a new digit in KEY_ENTRY; alarm outranks time
    always_comb begin
        w_next            = IDLE;
        bus.shift         = r_state == KEY_STORED;
        bus.show_new_time = r_state inside {KEY_STORED, KEY_WAITED, KEY_ENTRY};
        bus.show_a        = r_state == SHOW_ALARM;
        bus.load_new_a    = r_state == SET_ALARM_TIME;
        bus.load_new_c    = r_state == SET_CURRENT_TIME;
        case (r_state)
            IDLE:       w_next = w_digit ? KEY_STORED : bus.alarm_button ? SHOW_ALARM : IDLE;
            KEY_STORED: w_next = KEY_WAITED;
            KEY_WAITED: w_next = w_timeout ? IDLE : !w_digit ? KEY_ENTRY : KEY_WAITED;
            KEY_ENTRY:  w_next = w_timeout ? IDLE :
                                 (bus.alarm_button || bus.time_button) ?
                                     (!w_enough ? IDLE : bus.alarm_button ? SET_ALARM_TIME : SET_CURRENT_TIME) :
                                 w_digit ? KEY_STORED : KEY_ENTRY;
            SHOW_ALARM: w_next = bus.alarm_button ? SHOW_ALARM : IDLE;
            default:    w_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_aclk_fsm.sv
// tb_aclk_fsm: directed self-checking bench for aclk_fsm (both ACLK_DIGIT_CHECK_EN builds).
module tb_aclk_fsm;
    localparam logic [3:0] NK = 4'hA;
    // Output vector order: {load_new_a, load_new_c, show_a, show_new_time, shift}
    localparam logic [4:0] O_IDLE = 5'b00000;
    localparam logic [4:0] O_STOR = 5'b00011;
    localparam logic [4:0] O_NEW  = 5'b00010;
    localparam logic [4:0] O_SHOW = 5'b00100;
    localparam logic [4:0] O_LA   = 5'b10000;
    localparam logic [4:0] O_LC   = 5'b01000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    aclk_if ev ();
    aclk_fsm #(.KEY_TIMEOUT_S(10)) dut (.clk(clk), .reset(reset), .bus(ev));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {ev.load_new_a, ev.load_new_c, ev.show_a, ev.show_new_time, ev.shift};
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Digit held three sampled edges, then one release cycle; ends in KEY_ENTRY
    task automatic press(input logic [3:0] d, input logic [3:0] rel);
        ev.key = d;
        step(); chk($sformatf("stored_%0d", d), O_STOR);
        step(); chk($sformatf("waited_%0d", d), O_NEW);
        step(); chk($sformatf("held_%0d", d), O_NEW);
        ev.key = rel;
        step(); chk($sformatf("entry_%0d", d), O_NEW);
    endtask

    // Ten ticks with a gap cycle between; the 10th tick must abandon entry
    task automatic ten_ticks(input string tag);
        for (int i = 1; i <= 10; i++) begin
            ev.one_second = 1'b1;
            step(); chk($sformatf("%s_tick%0d", tag, i), i < 10 ? O_NEW : O_IDLE);
            ev.one_second = 1'b0;
            if (i == 10) ev.key = NK;
            step(); chk($sformatf("%s_gap%0d", tag, i), i < 10 ? O_NEW : O_IDLE);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ev.one_second = 1'b0; ev.key = NK; ev.alarm_button = 1'b0; ev.time_button = 1'b0;
        #1 chk("reset_async", O_IDLE);
        step(); step();
        reset = 1'b1;
        step(); chk("reset_idle", O_IDLE);

        // Reset mid-entry, and again with a load strobe in flight
        press(4'd9, NK);
        #2 reset = 1'b0;
        #1 chk("reset_mid_entry", O_IDLE);
        step(); reset = 1'b1;
        step(); chk("after_reset1", O_IDLE);
        press(4'd1, NK); press(4'd2, NK); press(4'd3, NK); press(4'd4, NK);
        ev.alarm_button = 1'b1;
        step(); chk("inflight_la", O_LA);
        #2 reset = 1'b0;
        #1 chk("reset_drops_strobe", O_IDLE);
        ev.alarm_button = 1'b0;
        step(); reset = 1'b1;
        step(); chk("after_reset2", O_IDLE);

        // Four digits then alarm_button for two cycles
        press(4'd1, NK); press(4'd2, NK); press(4'd3, NK); press(4'd4, NK);
        ev.alarm_button = 1'b1;
        step(); chk("load_a", O_LA);
        step(); chk("load_a_done", O_IDLE);
        ev.alarm_button = 1'b0;
        step(); chk("idle_after_load_a", O_IDLE);

        // Timeout from KEY_ENTRY, then from KEY_WAITED with key held
        press(4'd7, NK);
        ten_ticks("to_entry");
        ev.key = 4'd8;
        step(); chk("held8_stored", O_STOR);
        step(); chk("held8_waited", O_NEW);
        ten_ticks("to_waited");

        // alarm_button hold shows alarm; key during hold ignored
        ev.alarm_button = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            ev.key = (i == 2 || i == 3) ? 4'd5 : NK;
            step(); chk($sformatf("show_a_%0d", i), O_SHOW);
        end
        ev.alarm_button = 1'b0;
        step(); chk("show_a_release", O_IDLE);
        step(); chk("show_a_idle", O_IDLE);

        // Simultaneous buttons: alarm load wins; 4'hC/4'hF act as NOKEY
        press(4'd0, 4'hC); press(4'd9, 4'hF); press(4'd5, 4'hB); press(4'd8, NK);
        ev.alarm_button = 1'b1; ev.time_button = 1'b1;
        step(); chk("both_buttons", O_LA);
        ev.alarm_button = 1'b0; ev.time_button = 1'b0;
        step(); chk("both_done", O_IDLE);

        // Two digits then time_button
        press(4'd2, NK); press(4'd3, NK);
        ev.time_button = 1'b1;
`ifdef ACLK_DIGIT_CHECK_EN
        step(); chk("short_entry", O_IDLE);
`else
        step(); chk("short_entry", O_LC);
`endif
        ev.time_button = 1'b0;
        step(); chk("short_done", O_IDLE);

        // Digit beats alarm_button in IDLE
        ev.key = 4'd6; ev.alarm_button = 1'b1;
        step(); chk("digit_beats_alarm", O_STOR);
        ev.key = NK; ev.alarm_button = 1'b0;
        step(); chk("digit_beats_waited", O_NEW);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
